// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: funct3 access types,
// FSM state codes and the accept-time error rule.
package dmem_responder_pkg;

    // funct3 memory access encodings
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Responder FSM state codes
    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'd0,
        DMEM_READ  = 2'd1,
        DMEM_WRITE = 2'd2,
        DMEM_RESP  = 2'd3
    } dmem_state_e;

    // A request is rejected for an illegal funct3, a misaligned halfword or
    // word, or an unsigned type on a store (there is no unsigned store).
    function automatic logic req_err(input logic       we,
                                     input logic [2:0] t,
                                     input logic [1:0] a);
        logic e;
        case (t)
            MEM_B:   e = 1'b0;
            MEM_H:   e = a[0];
            MEM_W:   e = |a;
            MEM_BU:  e = we;
            MEM_HU:  e = we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for sub-word accesses: formats load data out of a word and
// merges store data into an old word for the read-modify-write path.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] load_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  type_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Load path: pick the addressed lane, then sign- or zero-extend it
    always_comb begin
        shifted = load_word_i >> {addr_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        case (type_i)
            MEM_B:   load_data_o = {{24{byte_v[7]}}, byte_v};
            MEM_BU:  load_data_o = {24'h0, byte_v};
            MEM_H:   load_data_o = {{16{half_v[15]}}, half_v};
            MEM_HU:  load_data_o = {16'h0, half_v};
            MEM_W:   load_data_o = load_word_i;
            default: load_data_o = 32'h0;
        endcase
    end

    // Store path: overwrite only the addressed lane, keep the other bytes
    always_comb begin
        store_word_o = old_word_i;
        case (type_i)
            MEM_B: store_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            MEM_H: begin
                if (addr_i[1]) store_word_o[31:16] = wdata_i[15:0];
                else           store_word_o[15:0]  = wdata_i[15:0];
            end
            MEM_W:   store_word_o = wdata_i;
            default: store_word_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder. Word-wide storage without byte
// enables, so byte/half stores go READ -> WRITE as read-modify-write.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    dmem_state_e       state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        type_q;
    logic [31:0]       old_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              acc_err;
    logic [ADDR_W-3:0] widx;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept  = req_valid && (state_q == DMEM_IDLE);
    assign acc_err = req_err(req_we, req_type, req_addr[1:0]);
    assign widx    = addr_q[ADDR_W-1:2];
    assign rd_word = mem_q[widx];

    dmem_lane_align u_align (
        .load_word_i  (rd_word),
        .old_word_i   (old_q),
        .wdata_i      (wdata_q),
        .addr_i       (addr_q[1:0]),
        .type_i       (type_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= DMEM_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: errors answer immediately, word stores skip the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    if (acc_err)                    state_d = DMEM_RESP;
                    else if (req_we && req_type == MEM_W) state_d = DMEM_WRITE;
                    else                            state_d = DMEM_READ;
                end
            end
            DMEM_READ:  state_d = we_q ? DMEM_WRITE : DMEM_RESP;
            DMEM_WRITE: state_d = DMEM_RESP;
            DMEM_RESP:  if (rsp_ready) state_d = DMEM_IDLE;
            default:    state_d = DMEM_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = (state_q == DMEM_IDLE);
        rsp_valid = (state_q == DMEM_RESP);
    end

    // Request latch; req_* are ignored outside the accept cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            type_q  <= req_type;
        end
    end

    // Old word captured in READ for the merge in WRITE
    always_ff @(posedge clk) begin
        if (state_q == DMEM_READ) old_q <= rd_word;
    end

    // Response registers: cleared at accept, load data filled in READ
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= acc_err;
        end else if (state_q == DMEM_READ && !we_q) begin
            rsp_rdata_q <= load_data;
        end
    end

    // Storage write; a reset on the WRITE edge abandons the store
    always_ff @(posedge clk) begin
        if (!rst && state_q == DMEM_WRITE) mem_q[widx] <= store_word;
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus randomized traffic against
// a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_type;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mb [1 << ADDR_W];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Reference: byte-addressed little-endian memory, access rules from funct3
    task automatic model(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, input logic [2:0] t,
                         output logic [31:0] rd, output logic err, output int lat);
        int sz;
        int ai;
        logic sgn;
        logic [31:0] v;
        sz = 1; sgn = 1'b0; err = 1'b0; rd = 32'h0; ai = int'(a);
        case (t)
            3'b000: begin sz = 1; sgn = 1'b1; end
            3'b001: begin sz = 2; sgn = 1'b1; end
            3'b010: begin sz = 4; sgn = 1'b0; end
            3'b100: begin sz = 1; sgn = 1'b0; end
            3'b101: begin sz = 2; sgn = 1'b0; end
            default: err = 1'b1;
        endcase
        if (!err && (ai % sz) != 0) err = 1'b1;
        if (!err && we && !sgn && sz != 4) err = 1'b1;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < sz; i++) mb[ai + i] = wd[8*i +: 8];
            lat = (sz == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[ai + i];
            if (sgn && v[8*sz-1])
                for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
            lat = 2;
        end
    endtask

    // Drive one request, wait (bounded) for the response, then handshake it.
    // lat counts edges from the accept edge to the first visible rsp_valid.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, input logic [2:0] t,
                         output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_type = t;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = ADDR_W'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); else n_pass++;
        n_total++; if (rsp_err !== 1'b0) $display("FAIL reset rsp_err: got %b want 0", rsp_err); else n_pass++;
        rst = 1'b0;
    endtask

    // Fill the words used later so reference and DUT start identical
    task automatic test_init;
        logic [31:0] rd, mrd, wd;
        logic err, merr;
        int lat, mlat;
        logic [ADDR_W-1:0] a;
        for (int w = 0; w < 65; w++) begin
            a  = (w == 64) ? ADDR_W'(14'h3FFC) : ADDR_W'(w * 4);
            wd = $urandom;
            model(1'b1, a, wd, 3'b010, mrd, merr, mlat);
            issue(1'b1, a, wd, 3'b010, rd, err, lat);
            n_total++; if (err !== 1'b0 || lat != 2) $display("FAIL init sw %h: err %b lat %0d want err 0 lat 2", a, err, lat); else n_pass++;
        end
    endtask

    task automatic test_word;
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, mlat;
        model(1'b1, 14'h10, 32'hDEADBEEF, 3'b010, mrd, merr, mlat);
        issue(1'b1, 14'h10, 32'hDEADBEEF, 3'b010, rd, err, lat);
        n_total++; if (err !== 1'b0) $display("FAIL sw err: got %b want 0", err); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL sw rdata: got %h want 0", rd); else n_pass++;
        n_total++; if (lat != 2) $display("FAIL sw latency: got %0d want 2", lat); else n_pass++;
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (err !== 1'b0) $display("FAIL lw err: got %b want 0", err); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw rdata: got %h want deadbeef", rd); else n_pass++;
        n_total++; if (lat != 2) $display("FAIL lw latency: got %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_subword_load;
        logic [ADDR_W-1:0] ta [4] = '{14'h13, 14'h13, 14'h10, 14'h12};
        logic [2:0]        tt [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0]       te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        logic [31:0] rd;
        logic err;
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, ta[i], 32'h0, tt[i], rd, err, lat);
            n_total++; if (rd !== te[i] || err !== 1'b0 || lat != 2)
                $display("FAIL subload %0d: rdata %h err %b lat %0d want %h 0 2", i, rd, err, lat, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_subword_store;
        logic [31:0] rd, mrd;
        logic err, merr;
        int lat, mlat;
        model(1'b1, 14'h11, 32'h000000AA, 3'b000, mrd, merr, mlat);
        issue(1'b1, 14'h11, 32'h000000AA, 3'b000, rd, err, lat);
        n_total++; if (err !== 1'b0 || lat != 3) $display("FAIL sb: err %b lat %0d want 0 3", err, lat); else n_pass++;
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (rd !== 32'hDEADAAEF) $display("FAIL sb readback: got %h want deadaaef", rd); else n_pass++;
        model(1'b1, 14'h12, 32'h00001234, 3'b001, mrd, merr, mlat);
        issue(1'b1, 14'h12, 32'h00001234, 3'b001, rd, err, lat);
        n_total++; if (err !== 1'b0 || lat != 3) $display("FAIL sh: err %b lat %0d want 0 3", err, lat); else n_pass++;
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (rd !== 32'h1234AAEF) $display("FAIL sh readback: got %h want 1234aaef", rd); else n_pass++;
    endtask

    task automatic test_errors;
        logic              tw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [ADDR_W-1:0] ta [4] = '{14'h12, 14'h21, 14'h10, 14'h10};
        logic [2:0]        tt [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] rd;
        logic err;
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(tw[i], ta[i], 32'h00000077, tt[i], rd, err, lat);
            n_total++; if (err !== 1'b1 || rd !== 32'h0 || lat != 1)
                $display("FAIL error case %0d: err %b rdata %h lat %0d want 1 0 1", i, err, rd, lat);
            else n_pass++;
        end
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (rd !== 32'h1234AAEF) $display("FAIL error untouched: got %h want 1234aaef", rd); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic err;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h10; req_type = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_total++; if (lat != 2) $display("FAIL hold latency: got %0d want 2", lat); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                @(negedge clk);
                req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h10;
                req_wdata = 32'hCAFEF00D; req_type = 3'b010;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234AAEF || req_ready !== 1'b0)
                $display("FAIL hold cycle %0d: valid %b rdata %h ready %b want 1 1234aaef 0", k, rsp_valid, rsp_rdata, req_ready);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL hold release: valid %b ready %b want 0 1", rsp_valid, req_ready);
        else n_pass++;
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (rd !== 32'h1234AAEF) $display("FAIL hold ignored req: got %h want 1234aaef", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic err;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h10;
        req_wdata = 32'h00000055; req_type = 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL midreset state: valid %b ready %b want 0 1", rsp_valid, req_ready);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL midreset idle: valid %b want 0", rsp_valid); else n_pass++;
        issue(1'b0, 14'h10, 32'h0, 3'b010, rd, err, lat);
        n_total++; if (rd !== 32'h1234AAEF) $display("FAIL midreset memory: got %h want 1234aaef", rd); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] rd, mrd, wd;
        logic err, merr, we;
        int lat, mlat;
        logic [ADDR_W-1:0] a;
        logic [2:0] t;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            t  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) a = ADDR_W'(14'h3FFC + $urandom_range(0, 3));
            else                           a = ADDR_W'($urandom_range(0, 255));
            model(we, a, wd, t, mrd, merr, mlat);
            issue(we, a, wd, t, rd, err, lat);
            n_total++; if (rd !== mrd || err !== merr || lat != mlat)
                $display("FAIL random %0d we %b a %h t %0d: rdata %h err %b lat %0d want %h %b %0d",
                         i, we, a, t, rd, err, lat, mrd, merr, mlat);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = 32'h0; req_type = 3'b0; rsp_ready = 1'b0;
        test_reset;
        test_init;
        test_word;
        test_subword_load;
        test_subword_store;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
